uart_tx_word_arbiter: RTL and testbench
=======================================

Name: uart_tx_word_arbiter

Overview:
- Shares the single byte-wide UART transmitter between two 32-bit word sources, A and B.
- A is the MIPS datapath result word; B is the status/debug word.
- Arbitrates round-robin and drives the source-select that steers the word mux.
- Serialises the granted word into bytes, LSB first, with a start/done handshake to the UART tx, then acknowledges the requester.

Parameters:
- LENGTH, 32, word width in bits; must be a nonzero multiple of 8.
- NBYTES, LENGTH/8, bytes per word. Derived localparam, not overridable.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- req_a  input  1  source A requests transmission of data_a
- data_a  input  LENGTH  source A word
- ack_a  output  1  one-cycle pulse: A's word fully sent
- req_b  input  1  source B requests transmission of data_b
- data_b  input  LENGTH  source B word
- ack_b  output  1  one-cycle pulse: B's word fully sent
- sel  output  1  current/last granted source, 0=A, 1=B (drives word mux select)
- tx_data  output  8  byte presented to UART tx
- tx_start  output  1  one-cycle pulse: UART tx loads tx_data
- tx_done  input  1  one-cycle pulse from UART tx: byte finished (stop bit sent)
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset values (all outputs registered):
  - tx_start=0, tx_data=8'h00, ack_a=0, ack_b=0, sel=0, busy=0.
  - state=IDLE, byte counter=0, shift register=0, last_grant=B, so A wins the first contention.
- States: IDLE, START, WAIT, DONE.
- IDLE:
  - If exactly one req is high, grant that source.
  - If both are high, grant the source != last_grant.
  - On grant: capture the granted word into the shift register, set sel to the winner, clear the byte counter, go to START.
  - If no req is high, stay in IDLE.
- START:
  - tx_start=1 for exactly this cycle; tx_data=shreg[7:0], registered.
  - Next state WAIT.
- WAIT:
  - tx_start=0; tx_data held stable.
  - On tx_done: if byte counter==NBYTES-1, go to DONE. Otherwise shift the register right by 8, increment the counter, go to START.
  - tx_done outside WAIT is ignored.
  - No timeout; WAIT holds indefinitely without tx_done.
- DONE:
  - Pulse ack_a or ack_b for one cycle according to sel.
  - Set last_grant=sel; go to IDLE.
- Latency:
  - Req sampled in IDLE at cycle N gives first tx_start at N+1.
  - First tx_start to ack is NBYTES handshakes plus 1 cycle (ack is asserted in the cycle after the final tx_done is sampled).
  - Minimum gap between words: DONE → IDLE → START, so the next tx_start comes 2 cycles after the ack cycle.
- Requester rules:
  - Data is sampled only at grant; data may change after grant without effect.
  - The requester must drop req in the cycle after its ack. A req still high in IDLE after DONE is treated as a new request.
  - Req is not sampled outside IDLE. A competing req simply waits.
- sel holds its value through IDLE until the next grant; it is never changed mid-word.
- Byte order: byte 0 = word[7:0] first; last byte = word[LENGTH-1:LENGTH-8].
- Reset mid-operation:
  - Abort immediately to IDLE and discard the word; no ack is issued.
  - tx_start drops the same cycle; all outputs return to reset values.
- tx_done coincident with reset: reset wins.

Test Plan:
- Single A: req_a with data_a=32'hDEADBEEF → sel=0; tx_start ×4 with tx_data 8'hEF, 8'hBE, 8'hAD, 8'hDE; ack_a one cycle after the 4th tx_done is sampled; ack_b never asserted.
- Contention: req_a and req_b high in the same cycle from reset (A=32'h11223344, B=32'hAABBCCDD) → A served first (44, 33, 22, 11, ack_a); then B (DD, CC, BB, AA, ack_b, sel=1); a second simultaneous pair is served A first again.
- Fairness: keep req_b high continuously, pulse req_a repeatedly → grants alternate A, B, A, B; B is never starved.
- Data change after grant: change data_a to 32'h0 one cycle after grant → transmitted bytes still equal the captured word.
- Stalled UART: delay tx_done 50 cycles on byte 2 → tx_data stable, no extra tx_start, busy=1 throughout.
- Reset mid-word: assert rst after the 2nd tx_done → next cycle busy=0, tx_start=0, no ack; a later req_b transmits from byte 0.

Source files
------------

// File: rtl/uart_tx_word_arbiter.sv
// Round-robin arbiter that shares one byte-wide UART transmitter between two
// word sources and serialises the granted word LSB-first.
module uart_tx_word_arbiter #(
  parameter int LENGTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic [LENGTH-1:0] data_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic [LENGTH-1:0] data_b,
  output logic              ack_b,
  output logic              sel,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              busy,
  output logic [1:0]        state_dbg
);
  localparam int NBYTES = LENGTH / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  // Handshakes: a requester holds req until its one-cycle ack; toward the UART,
  // tx_start and tx_done are one-cycle pulses and tx_data is stable in between.
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LENGTH-1:0] shreg_q, shreg_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic              busy_q, busy_d;

  logic              win;
  logic [LENGTH-1:0] grant_word;
  logic [LENGTH-1:0] shifted;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    last_d     = last_q;
    sel_d      = sel_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    // On contention the source that was not served last wins.
    win        = (req_a && req_b) ? ~last_q : req_b;
    grant_word = win ? data_b : data_a;
    shifted    = shreg_q >> 8;

    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          sel_d      = win;
          shreg_d    = grant_word;
          cnt_d      = '0;
          tx_data_d  = grant_word[7:0];
          tx_start_d = 1'b1;
          state_d    = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (cnt_q == LAST_BYTE) begin
            ack_a_d = ~sel_q;
            ack_b_d = sel_q;
            state_d = DONE;
          end else begin
            shreg_d    = shifted;
            cnt_d      = cnt_q + CNT_W'(1);
            tx_data_d  = shifted[7:0];
            tx_start_d = 1'b1;
            state_d    = START;
          end
        end
      end
      DONE: begin
        last_d  = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      busy_q     <= busy_d;
    end
  end

  assign ack_a     = ack_a_q;
  assign ack_b     = ack_b_q;
  assign sel       = sel_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_word_arbiter.sv
// Randomised bench for uart_tx_word_arbiter: transaction-level model of the
// arbitration and byte stream, with a UART responder of random latency.
module tb_uart_tx_word_arbiter;
  localparam int LENGTH = 32;
  localparam int NBYTES = LENGTH / 8;

  logic              clk;
  logic              rst;
  logic              req_a, req_b;
  logic [LENGTH-1:0] data_a, data_b;
  logic              ack_a, ack_b;
  logic              sel;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_done;
  logic              busy;
  logic [1:0]        state_dbg;

  uart_tx_word_arbiter #(.LENGTH(LENGTH)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .sel(sel), .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard and model state
  logic [7:0] exp_q[$];
  bit         serve_log[$];
  bit         m_idle, idle_soon, m_sel, m_last, m_cur, outstanding;
  bit         exp_start, exp_ack_a, exp_ack_b;
  int         m_done_cnt, wait_cnt;
  logic [7:0] held;
  bit         pend_a, pend_b, keep_b, scr_a, scr_b, stall_en, spur_en;
  int         prob_a, prob_b, acks_a, acks_b, n_starts;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: observe and check at the falling edge, then drive the next inputs.
  task automatic step();
    logic [LENGTH-1:0] word;
    bit win;
    @(negedge clk);
    if (idle_soon) begin
      m_idle    = 1'b1;
      idle_soon = 1'b0;
    end
    check("busy", busy, !m_idle);
    check("sel", sel, m_sel);
    check("tx_start", tx_start, exp_start);
    check("ack_a", ack_a, exp_ack_a);
    check("ack_b", ack_b, exp_ack_b);
    if (tx_start) n_starts++;
    if (exp_start && exp_q.size() > 0) begin
      held = exp_q.pop_front();
      check("tx_data", tx_data, held);
      outstanding = 1'b1;
      wait_cnt = (stall_en && m_done_cnt == 2) ? 50 : int'($urandom_range(4, 1));
    end else if (outstanding) begin
      check("tx_hold", tx_data, held);
    end
    if (exp_ack_a || exp_ack_b) begin
      idle_soon = 1'b1;
      m_last    = m_cur;
    end
    if (ack_a) begin acks_a++; serve_log.push_back(1'b0); end
    if (ack_b) begin acks_b++; serve_log.push_back(1'b1); end
    exp_start = 1'b0;
    exp_ack_a = 1'b0;
    exp_ack_b = 1'b0;

    // requesters
    if (scr_a) begin data_a = '0; scr_a = 1'b0; end
    if (scr_b) begin data_b = $urandom; scr_b = 1'b0; end
    if (ack_a) pend_a = 1'b0;
    if (ack_b && !keep_b) pend_b = 1'b0;
    if (!pend_a && !ack_a && int'($urandom_range(99, 0)) < prob_a) begin
      pend_a = 1'b1;
      data_a = $urandom;
    end
    if (!pend_b && !ack_b && int'($urandom_range(99, 0)) < prob_b) begin
      pend_b = 1'b1;
      data_b = $urandom;
    end
    req_a = pend_a;
    req_b = pend_b;

    // UART responder
    tx_done = 1'b0;
    if (outstanding) begin
      if (wait_cnt == 0) begin
        tx_done     = 1'b1;
        outstanding = 1'b0;
        m_done_cnt++;
        if (m_done_cnt == NBYTES) begin
          exp_ack_a = !m_cur;
          exp_ack_b = m_cur;
        end else begin
          exp_start = 1'b1;
        end
      end else begin
        wait_cnt--;
      end
    end else if (spur_en && $urandom_range(7, 0) == 0) begin
      tx_done = 1'b1;
    end

    // arbitration seen from outside: requests present while idle start a word next cycle
    if (m_idle && (req_a || req_b)) begin
      win  = (req_a && req_b) ? !m_last : req_b;
      word = win ? data_b : data_a;
      for (int i = 0; i < NBYTES; i++) exp_q.push_back(word[8*i +: 8]);
      m_cur      = win;
      m_sel      = win;
      m_idle     = 1'b0;
      m_done_cnt = 0;
      exp_start  = 1'b1;
      if (win) scr_b = 1'b1;
      else     scr_a = 1'b1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst     = 1'b1;
    tx_done = 1'b1;
    req_a   = 1'b0;
    req_b   = 1'b0;
    pend_a  = 1'b0;
    pend_b  = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_ack_a", ack_a, 0);
    check("rst_ack_b", ack_b, 0);
    check("rst_sel", sel, 0);
    check("rst_tx_data", tx_data, 8'h00);
    rst     = 1'b0;
    tx_done = 1'b0;
    exp_q.delete();
    m_idle      = 1'b1;
    idle_soon   = 1'b0;
    m_sel       = 1'b0;
    m_last      = 1'b1;
    outstanding = 1'b0;
    exp_start   = 1'b0;
    exp_ack_a   = 1'b0;
    exp_ack_b   = 1'b0;
    m_done_cnt  = 0;
    scr_a       = 1'b0;
    scr_b       = 1'b0;
  endtask

  task automatic run_words(input int n, input int budget);
    int target;
    int cyc;
    target = acks_a + acks_b + n;
    cyc    = 0;
    while (acks_a + acks_b < target && cyc < budget) begin
      step();
      cyc++;
    end
    check("ack_count", acks_a + acks_b, target);
  endtask

  task automatic drain(input int budget);
    int cyc;
    cyc = 0;
    while (!(m_idle && !idle_soon && !pend_a && !pend_b) && cyc < budget) begin
      step();
      cyc++;
    end
    step();
    check("drain_busy", busy, 0);
  endtask

  initial begin
    int a0, s0, cyc;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; tx_done = 1'b0;
    data_a = '0; data_b = '0;
    pend_a = 0; pend_b = 0; keep_b = 0; scr_a = 0; scr_b = 0;
    stall_en = 0; spur_en = 0; prob_a = 0; prob_b = 0;
    acks_a = 0; acks_b = 0; n_starts = 0;
    apply_reset();
    repeat (3) step();

    // single A word
    data_a = 32'hDEADBEEF;
    pend_a = 1'b1;
    run_words(1, 200);
    check("single_acks_a", acks_a, 1);
    check("single_acks_b", acks_b, 0);

    // contention from reset, twice
    apply_reset();
    serve_log.delete();
    data_a = 32'h11223344; data_b = 32'hAABBCCDD;
    pend_a = 1'b1; pend_b = 1'b1;
    run_words(2, 200);
    data_a = $urandom; data_b = $urandom;
    pend_a = 1'b1; pend_b = 1'b1;
    run_words(2, 200);
    check("contention_n", serve_log.size(), 4);
    for (int i = 0; i < serve_log.size() && i < 4; i++)
      check("contention_order", serve_log[i], i % 2);

    // fairness: B held high, A re-requests after each ack
    serve_log.delete();
    keep_b = 1'b1; pend_b = 1'b1; data_b = $urandom; prob_a = 100;
    run_words(8, 400);
    keep_b = 1'b0; prob_a = 0;
    for (int i = 1; i < serve_log.size(); i++)
      check("fair_alternate", serve_log[i], !serve_log[i-1]);
    drain(400);

    // stalled UART on byte 2
    stall_en = 1'b1;
    s0 = n_starts;
    data_a = $urandom; pend_a = 1'b1;
    run_words(1, 300);
    stall_en = 1'b0;
    check("stall_starts", n_starts - s0, NBYTES);

    // reset after the second tx_done of a word
    a0 = acks_a;
    data_a = $urandom; pend_a = 1'b1;
    cyc = 0;
    while (!(m_done_cnt == 2 && !m_idle) && cyc < 100) begin
      step();
      cyc++;
    end
    check("midword_reached", m_done_cnt, 2);
    apply_reset();
    repeat (5) step();
    check("midword_no_ack", acks_a, a0);
    serve_log.delete();
    data_b = 32'hCAFEF00D; pend_b = 1'b1;
    run_words(1, 200);
    check("after_rst_src", serve_log.size() > 0 ? serve_log[0] : 1'b0, 1);

    // random traffic with spurious tx_done outside byte waits
    spur_en = 1'b1; prob_a = 15; prob_b = 15;
    run_words(120, 20000);
    prob_a = 0; prob_b = 0;
    drain(400);
    spur_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
